// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the tiled sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int num_tiles(input int w, input int t);
    return (t > 0) ? (w / t) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_tile.sv
// Combinational unsigned TxT -> 2T tile multiplier, shared by the iterator.
module mult_tile #(
  parameter int T = 2
) (
  input  logic [T-1:0]   i_a,
  input  logic [T-1:0]   i_b,
  output logic [2*T-1:0] o_p
);

  assign o_p = (2*T)'(i_a) * (2*T)'(i_b);

endmodule

// File: rtl/mult_seq_tiled.sv
// Iterative WxW unsigned multiplier reusing one TxT tile over N*N cycles,
// with valid/ready handshakes on operands and result.
module mult_seq_tiled #(
  parameter int W = 8,
  parameter int T = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);
  import mult_pkg::*;

  localparam int N  = num_tiles(W, T);
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (T < 1) begin : g_bad_t
    $error("mult_seq_tiled: T must be >= 1");
  end else if (W % T != 0) begin : g_bad_w
    $error("mult_seq_tiled: W must be a multiple of T");
  end

  state_t r_state;
  state_t w_next;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IW-1:0]  r_i;
  logic [IW-1:0]  r_j;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_p;

  logic [T-1:0]   w_ta;
  logic [T-1:0]   w_tb;
  logic [2*T-1:0] w_tp;
  logic [31:0]    w_sh;
  logic [2*W-1:0] w_sum;
  logic           w_last;
  logic           w_accept;

  assign w_ta = T'(r_a >> (32'(r_i) * 32'(T)));
  assign w_tb = T'(r_b >> (32'(r_j) * 32'(T)));
  assign w_sh = 32'(T) * (32'(r_i) + 32'(r_j));

  mult_tile #(
    .T(T)
  ) u_tile (
    .i_a(w_ta),
    .i_b(w_tb),
    .o_p(w_tp)
  );

  assign w_sum    = r_acc + ((2*W)'(w_tp) << w_sh);
  assign w_last   = (r_i == LAST) && (r_j == LAST);
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_acc <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_i   <= '0;
      r_j   <= '0;
      r_acc <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_sum;
      if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
      if (w_last) r_p <= w_sum;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign p         = r_p;

endmodule

// File: tb/tb_mult_seq_tiled.sv
// Self-checking bench for mult_seq_tiled against plain a*b arithmetic.
module tb_mult_seq_tiled;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] p;

  logic        v4, or4, rd4, ov4, bz4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        v16, or16, rd16, ov16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        v2, or2, rd2, ov2, bz2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  mult_seq_tiled #(.W(8), .T(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  mult_seq_tiled #(.W(4), .T(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rd4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
    .p(p4), .busy(bz4)
  );

  mult_seq_tiled #(.W(16), .T(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rd16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
    .p(p16), .busy(bz16)
  );

  mult_seq_tiled #(.W(2), .T(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rd2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2),
    .p(p2), .busy(bz2)
  );

  task automatic run8(input logic [7:0] xa, input logic [7:0] xb,
                      input bit tog, output int lat, output bit to);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    to  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (tog) begin
        a = k[0] ? 8'h33 : 8'h44;
        b = k[0] ? 8'h44 : 8'h33;
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0;
    v4 = 0; or4 = 1; a4 = 0; b4 = 0;
    v16 = 0; or16 = 1; a16 = 0; b16 = 0;
    v2 = 0; or2 = 1; a2 = 0; b2 = 0;
    #12;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    total++;
    if (p !== 16'h0) $display("FAIL reset_p got %h want 0000", p);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    int lat; bit to;
    out_ready = 1'b1;
    run8(8'hFF, 8'hFF, 1'b0, lat, to);
    total++;
    if (to || lat != 16) $display("FAIL max_latency got %0d want 16", lat);
    else passed++;
    total++;
    if (p !== 16'(255 * 255)) $display("FAIL max_p got %h want %h", p, 16'(255 * 255));
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL max_one_cycle got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    out_ready = 1'b1;
    run8(8'h0D, 8'h0B, 1'b0, lat, to);
    total++;
    if (to || p !== 16'(13 * 11)) $display("FAIL b2b_first got %h want %h", p, 16'(13 * 11));
    else passed++;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", in_ready);
    else passed++;
    run8(8'h00, 8'hA5, 1'b0, lat, to);
    total++;
    if (to || lat != 16 || p !== 16'h0)
      $display("FAIL b2b_second got p=%h lat=%0d want p=0000 lat=16", p, lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    out_ready = 1'b0;
    run8(8'h0D, 8'h0B, 1'b0, lat, to);
    total++;
    if (to) $display("FAIL bp_done got timeout want out_valid");
    else passed++;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if (p !== 16'h008F || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold got p=%h ov=%b rdy=%b want p=008f ov=1 rdy=0",
                 p, out_valid, in_ready);
      else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release got rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    else passed++;
  endtask

  task automatic test_mid_change();
    int lat; bit to;
    out_ready = 1'b1;
    run8(8'h12, 8'h34, 1'b1, lat, to);
    total++;
    if (to || lat != 16 || p !== 16'(18 * 52))
      $display("FAIL mid_change got p=%h lat=%0d want p=%h lat=16", p, lat, 16'(18 * 52));
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to;
    out_ready = 1'b1;
    a = 8'h55; b = 8'h66; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (p !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid got p=%h ov=%b busy=%b want 0000 0 0", p, out_valid, busy);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", in_ready);
    else passed++;
    @(posedge clk); #1;
    run8(8'h80, 8'h02, 1'b0, lat, to);
    total++;
    if (to || lat != 16 || p !== 16'h0100)
      $display("FAIL rst_mid_next got p=%h lat=%0d want 0100 16", p, lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random8();
    int lat; bit to;
    logic [7:0] xa, xb;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      xa = 8'($urandom);
      xb = 8'($urandom);
      run8(xa, xb, 1'b0, lat, to);
      total++;
      if (to || lat != 16 || p !== 16'(xa) * 16'(xb))
        $display("FAIL rand8 %h*%h got p=%h lat=%0d want %h", xa, xb, p, lat,
                 16'(xa) * 16'(xb));
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_w4_exhaustive();
    int lat;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 50) begin
          @(posedge clk); #1;
          lat++;
        end
        total++;
        if (lat != 4 || p4 !== 8'(x * y))
          $display("FAIL w4 %0d*%0d got p=%h lat=%0d want %h lat=4", x, y, p4, lat, 8'(x * y));
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_w16_random();
    int lat;
    logic [15:0] xa, xb;
    for (int n = 0; n < 1000; n++) begin
      xa = 16'($urandom);
      xb = 16'($urandom);
      a16 = xa; b16 = xb; v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0;
      lat = 0;
      while (!ov16 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat != 16 || p16 !== 32'(xa) * 32'(xb))
        $display("FAIL w16 %h*%h got p=%h lat=%0d want %h lat=16", xa, xb, p16, lat,
                 32'(xa) * 32'(xb));
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_w2_latency();
    int lat;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        a2 = 2'(x); b2 = 2'(y); v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        total++;
        if (lat != 1 || p2 !== 4'(x * y))
          $display("FAIL w2 %0d*%0d got p=%h lat=%0d want %h lat=1", x, y, p2, lat, 4'(x * y));
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_mid_change();
    test_reset_mid_run();
    test_random8();
    test_w4_exhaustive();
    test_w16_random();
    test_w2_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_seq_tiled.md
# mult_seq_tiled

Parametrised, iterative unsigned multiplier. It computes a W×W product by reusing a single T×T tile multiplier over (W/T)² cycles and accumulating shifted partial products. It is the sequential, area-lean successor to the fixed 4-bit, four-tile combinational multiplier. It sits behind a valid/ready handshake on both operand and result sides so it can be dropped into streaming datapaths.

## Interface
- W, default 8: operand width in bits; must be a multiple of T.
- T, default 2: tile (sub-multiplier) width in bits; N = W/T tiles per operand.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair a/b is valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  W  multiplicand, unsigned.
- b  in  W  multiplier, unsigned.
- out_valid  out  1  p holds a finished product.
- out_ready  in  1  consumer accepts p.
- p  out  2W  product a×b, unsigned.
- busy  out  1  high in RUN or DONE.

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a, b; clear acc; i=j=0; go to RUN.
- RUN: each cycle, acc += tile(a[i*T+:T], b[j*T+:T]) << (T*(i+j)).
  - j increments; on j=N-1, j wraps to 0 and i increments.
  - After the step with i=j=N-1, load p with the final sum and go to DONE.
- DONE:
  - out_valid=1; p held stable.
  - On out_ready, go to IDLE and drop out_valid.
- Width rules:
  - acc and p are 2W bits; the product always fits, so there is no overflow or truncation.
  - Tile result is 2T bits, zero-extended before the shift.
- Elaboration fails if W%T≠0 or T<1. W=T is legal: N=1, single RUN step.
- Inputs a/b/in_valid are ignored outside IDLE. The registered operand copy is used, so input changes mid-operation have no effect.
- No overlap: a new operand pair is not accepted while RUN or DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, acc=0, i=j=0, p=0, out_valid=0, busy=0.
  - in_ready=1 after reset; any in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, p=0, busy=0.
- Accept edge E0: RUN occupies edges E1..E(N²). out_valid rises after edge E(N²), i.e. N² cycles after acceptance (W=8, T=2: 16 cycles).
- The result handshake completes on the edge where out_valid&&out_ready. in_ready is high the following cycle. The earliest next accept is one cycle later.
- Throughput: one product per N²+2 cycles with out_ready tied high.
- in_ready and out_valid are decoded from registered state; there are no combinational in→out paths.

## Structure
- Package mult_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - a localparam function for N and the index width clog2(N).
- Sub-module mult_tile: parametrised T×T → 2T combinational unsigned multiplier, instantiated once. It is the single shared tile, replacing the four fixed tile instances of the combinational version.
- Top module: FSM, i/j counters, operand registers, 2W-bit accumulator, result register.

## Test plan
- W=8, T=2: a=0xFF, b=0xFF, out_ready=1 -> p=0xFE01; out_valid asserted exactly 16 cycles after the accept edge, for one cycle.
- W=8, T=2: a=0x0D, b=0x0B -> p=0x008F; then a=0x00, b=0xA5 -> p=0x0000, accepted one cycle after the first result handshake.
- Backpressure: out_ready held low 5 cycles in DONE -> p stays 0x8F and out_valid stays 1; in_ready stays 0; in_valid pulses are ignored. Release -> IDLE next cycle.
- Mid-operation change: a/b toggled to 0x33/0x44 during RUN of 0x12×0x34 -> p=0x03A8 (unaffected).
- Reset at the 7th RUN cycle -> immediately p=0, out_valid=0, busy=0; in_ready=1 after deassert. Next op 0x80×0x02 -> p=0x0100.
- Parameter sweep:
  - W=4, T=2: exhaustive 256 pairs match a×b with latency 4.
  - W=16, T=4: 1000 random pairs match with latency 16.
  - W=T=2: latency 1.
